// File: rtl/stopwatch_pkg.sv
// Shared state encoding, BCD digit limits and the two-digit BCD increment
// used by the stopwatch control block and its counter slices.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } swState_t;

  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h99;

  // Any units digit of 9 or above rolls to 0, so A-F can never appear there.
  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter slice: wraps to 00 after MAX and flags carry in the
// enabled cycle that holds MAX, so slices chain into a ripple-carry counter.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] q,
  output logic       carry
);

  assign carry = en && (q == MAX);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR)       q <= '0;
    else if (clr)   q <= '0;
    else if (carry) q <= '0;
    else if (en)    q <= bcdInc(q);
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key synchronizers and edge detect, IDLE/RUN/PAUSE/LAP FSM,
// 10 ms prescaler, BCD mm:ss.cc counter and lap display. Define
// STOPWATCH_DEBOUNCE_EN to insert a per-key debounce filter before edge detect.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       key_ss,
  input  logic       key_lr,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_cs,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  // bit 0 = start/stop, bit 1 = lap/reset
  logic [1:0] keyMeta;
  logic [1:0] keySync;
  logic [1:0] keyLvl;
  logic [1:0] keyPrev;
  logic [1:0] keyPulse;
  logic       ssP;
  logic       lrP;

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      keyMeta <= '0;
      keySync <= '0;
      keyPrev <= '0;
    end else begin
      keyMeta <= {key_lr, key_ss};
      keySync <= keyMeta;
      keyPrev <= keyLvl;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int            DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_TOP = DW'(DEBOUNCE_CYCLES - 1);

  for (genvar k = 0; k < 2; k++) begin : gDebounce
    logic [DW-1:0] dbCnt;
    logic          dbLvl;

    // The filtered level only follows the synchronizer after it has held a
    // new value for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
        dbCnt <= '0;
        dbLvl <= 1'b0;
      end else if (keySync[k] == dbLvl) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_TOP) begin
        dbCnt <= '0;
        dbLvl <= keySync[k];
      end else begin
        dbCnt <= dbCnt + DW'(1);
      end
    end

    assign keyLvl[k] = dbLvl;
  end
`else
  logic unusedDebounceCycles;
  assign unusedDebounceCycles = (DEBOUNCE_CYCLES > 0);
  assign keyLvl = keySync;
`endif

  assign keyPulse = keyLvl & ~keyPrev;
  assign ssP      = keyPulse[0];
  assign lrP      = keyPulse[1];

  swState_t      state;
  logic [PW-1:0] presc;
  logic [7:0]    minQ;
  logic [7:0]    secQ;
  logic [7:0]    csQ;
  logic [7:0]    snapMin;
  logic [7:0]    snapSec;
  logic [7:0]    snapCs;
  logic          counting;
  logic          tick;
  logic          atMax;
  logic          tickOvf;
  logic          cntEn;
  logic          cntClr;
  logic          takeLap;
  logic          csCarry;
  logic          secCarry;
  logic          unusedMinCarry;

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PRESC_TOP);
  assign atMax    = (minQ == MIN_MAX) && (secQ == SEC_MAX) && (csQ == CS_MAX);
  // A tick at full scale saturates instead of wrapping back to 00:00.00.
  assign tickOvf  = tick && atMax;
  assign cntEn    = tick && !atMax;
  // ss_p has priority, so a coincident lr_p never clears or snapshots.
  assign cntClr   = lrP && !ssP && ((state == IDLE) || (state == PAUSE));
  assign takeLap  = lrP && !ssP && !tickOvf && (state == RUN);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR)          presc <= '0;
    else if (cntClr)   presc <= '0;
    else if (tick)     presc <= '0;
    else if (counting) presc <= presc + PW'(1);
  end

  bcd2_counter #(.MAX(CS_MAX)) uCs (
    .CP   (CP),
    .nCR  (nCR),
    .clr  (cntClr),
    .en   (cntEn),
    .q    (csQ),
    .carry(csCarry)
  );

  bcd2_counter #(.MAX(SEC_MAX)) uSec (
    .CP   (CP),
    .nCR  (nCR),
    .clr  (cntClr),
    .en   (csCarry),
    .q    (secQ),
    .carry(secCarry)
  );

  bcd2_counter #(.MAX(MIN_MAX)) uMin (
    .CP   (CP),
    .nCR  (nCR),
    .clr  (cntClr),
    .en   (secCarry),
    .q    (minQ),
    .carry(unusedMinCarry)
  );

  // Snapshot holds the value the counter showed in the cycle lr_p was seen.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      snapMin <= '0;
      snapSec <= '0;
      snapCs  <= '0;
    end else if (takeLap) begin
      snapMin <= minQ;
      snapSec <= secQ;
      snapCs  <= csQ;
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else if (tickOvf) begin
      state      <= PAUSE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (ssP) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (ssP) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (lrP) begin
            state      <= LAP;
            lap_active <= 1'b1;
          end
        end
        LAP: begin
          if (ssP) begin
            state      <= PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lrP) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        PAUSE: begin
          if (ssP) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (lrP) begin
            state    <= IDLE;
            overflow <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

  // Display selects between two register banks, so it moves on the same edge
  // as the counter with no extra pipeline stage.
  assign disp_min = lap_active ? snapMin : minQ;
  assign disp_sec = lap_active ? snapSec : secQ;
  assign disp_cs  = lap_active ? snapCs  : csQ;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, corner sequences and a
// randomized run compared against a centisecond-based reference model.
module tb_stopwatch_ctrl;

  localparam int TICK = 4;
  localparam int DBC  = 8;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int HOLD = DBC + 4;
`else
  localparam int HOLD = 1;
`endif
  localparam int MAXT = 99 * 6000 + 59 * 100 + 99;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       keySs = 1'b0;
  logic       keyLr = 1'b0;
  logic [7:0] dispMin;
  logic [7:0] dispSec;
  logic [7:0] dispCs;
  logic       running;
  logic       lapActive;
  logic       overflow;

  int nChecks = 0;
  int nFail   = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK), .DEBOUNCE_CYCLES(DBC)) dut (
    .CP        (CP),
    .nCR       (nCR),
    .key_ss    (keySs),
    .key_lr    (keyLr),
    .disp_min  (dispMin),
    .disp_sec  (dispSec),
    .disp_cs   (dispCs),
    .running   (running),
    .lap_active(lapActive),
    .overflow  (overflow)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOut(input string name, input bit run, input bit lap, input bit ovf,
                          input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] cs);
    check({name, ".running"}, 32'(running), 32'(run));
    check({name, ".lap"}, 32'(lapActive), 32'(lap));
    check({name, ".ovf"}, 32'(overflow), 32'(ovf));
    check({name, ".min"}, 32'(dispMin), 32'(mn));
    check({name, ".sec"}, 32'(dispSec), 32'(sc));
    check({name, ".cs"}, 32'(dispCs), 32'(cs));
  endtask

  task automatic doReset();
    @(negedge CP);
    nCR = 1'b0; keySs = 1'b0; keyLr = 1'b0;
    repeat (2) @(negedge CP);
    nCR = 1'b1;
  endtask

  task automatic pressKey(input bit ss, input bit lr);
    keySs = ss; keyLr = lr;
    repeat (HOLD) @(posedge CP);
    #1 keySs = 1'b0; keyLr = 1'b0;
  endtask

  // Reference model: elapsed time as a plain count of centiseconds.
  int   mMode, mPhase, mT, mSnap;
  bit   mOvf;
  logic [2:0] ssH, lrH;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [23:0] timeBcd(input int t);
    return {bcd(t / 6000), bcd((t / 100) % 60), bcd(t % 100)};
  endfunction

  task automatic modelReset();
    mMode = 0; mPhase = 0; mT = 0; mSnap = 0; mOvf = 0; ssH = '0; lrH = '0;
  endtask

  task automatic modelStep(input logic ss, input logic lr);
    bit ssP, lrP, counting, tick;
    int oldT, oldMode;
    ssP = ssH[1] && !ssH[2];
    lrP = lrH[1] && !lrH[2];
    ssH = {ssH[1:0], ss};
    lrH = {lrH[1:0], lr};
    oldT = mT; oldMode = mMode;
    counting = (oldMode == 1) || (oldMode == 3);
    tick = counting && (mPhase == TICK - 1);
    if (counting) mPhase = tick ? 0 : mPhase + 1;
    if (tick && oldT == MAXT) begin
      mOvf = 1; mMode = 2;
    end else begin
      if (tick) mT = oldT + 1;
      case (oldMode)
        0: if (ssP) mMode = 1; else if (lrP) mT = 0;
        1: if (ssP) mMode = 2; else if (lrP) begin mMode = 3; mSnap = oldT; end
        3: if (ssP) mMode = 2; else if (lrP) mMode = 1;
        default: if (ssP) mMode = 1;
                 else if (lrP) begin mMode = 0; mT = 0; mPhase = 0; mOvf = 0; end
      endcase
    end
  endtask

  task automatic checkModel(input string name);
    logic [26:0] exp, act;
    exp = {(mMode == 1) || (mMode == 3), mMode == 3, mOvf, timeBcd((mMode == 3) ? mSnap : mT)};
    act = {running, lapActive, overflow, dispMin, dispSec, dispCs};
    check(name, 32'(act), 32'(exp));
  endtask

  typedef struct {
    bit         rst;
    bit         ss;
    bit         lr;
    int         w;
    bit         run;
    bit         lap;
    logic [7:0] mn;
    logic [7:0] sc;
    logic [7:0] cs;
    string      name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 1, 0, 400, 1, 0, 8'h00, 8'h00, 8'h99, "run400"};
    vecs[1]  = '{0, 0, 0, 4,   1, 0, 8'h00, 8'h01, 8'h00, "run404"};
    vecs[2]  = '{1, 1, 0, 200, 1, 0, 8'h00, 8'h00, 8'h49, "toPause"};
    vecs[3]  = '{0, 1, 0, 40,  0, 0, 8'h00, 8'h00, 8'h50, "pauseHold"};
    vecs[4]  = '{0, 1, 0, 6,   1, 0, 8'h00, 8'h00, 8'h50, "resumeNoTick"};
    vecs[5]  = '{0, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h51, "resumeTick"};
    vecs[6]  = '{1, 1, 0, 122, 1, 0, 8'h00, 8'h00, 8'h29, "toLap"};
    vecs[7]  = '{0, 0, 1, 80,  1, 1, 8'h00, 8'h00, 8'h30, "lapFrozen"};
    vecs[8]  = '{0, 0, 1, 3,   1, 0, 8'h00, 8'h00, 8'h50, "lapLive"};
    vecs[9]  = '{1, 1, 0, 20,  1, 0, 8'h00, 8'h00, 8'h04, "toBoth"};
    vecs[10] = '{0, 1, 1, 10,  0, 0, 8'h00, 8'h00, 8'h05, "ssWins"};
    vecs[11] = '{0, 0, 1, 4,   0, 0, 8'h00, 8'h00, 8'h00, "pauseClear"};

    repeat (3) @(negedge CP);
    checkOut("reset", 0, 0, 0, 8'h00, 8'h00, 8'h00);
    nCR = 1'b1;

`ifdef STOPWATCH_DEBOUNCE_EN
    doReset();
    keySs = 1'b1;
    repeat (5) @(posedge CP);
    #1 keySs = 1'b0;
    repeat (20) @(posedge CP);
    @(negedge CP);
    checkOut("glitch", 0, 0, 0, 8'h00, 8'h00, 8'h00);
    pressKey(1, 0);
    repeat (4) @(posedge CP);
    @(negedge CP);
    check("dbPress.running", 32'(running), 32'd1);
`else
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) doReset();
      pressKey(vecs[i].ss, vecs[i].lr);
      repeat (vecs[i].w - 1) @(posedge CP);
      @(negedge CP);
      checkOut(vecs[i].name, vecs[i].run, vecs[i].lap, 1'b0, vecs[i].mn, vecs[i].sc, vecs[i].cs);
    end

    // Overflow: minutes and seconds pinned at full scale, centiseconds run up.
    doReset();
    force dut.uMin.q = 8'h99;
    force dut.uSec.q = 8'h59;
    pressKey(1, 0);
    repeat (397) @(posedge CP);
    @(negedge CP);
    checkOut("preload", 1, 0, 0, 8'h99, 8'h59, 8'h98);
    repeat (8) @(posedge CP);
    @(negedge CP);
    checkOut("ovfHold", 0, 0, 1, 8'h99, 8'h59, 8'h99);
    release dut.uMin.q;
    release dut.uSec.q;
    pressKey(0, 1);
    repeat (2) @(posedge CP);
    @(negedge CP);
    checkOut("ovfClear", 0, 0, 0, 8'h00, 8'h00, 8'h00);

    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) keySs = ~keySs;
      if ($urandom_range(0, 31) == 0) keyLr = ~keyLr;
      @(posedge CP);
      modelStep(keySs, keyLr);
      @(negedge CP);
      checkModel("rand");
    end
`endif

    // Asynchronous reset between clock edges while counting.
    doReset();
    pressKey(1, 0);
    repeat (60) @(posedge CP);
    @(negedge CP);
    check("preRst.running", 32'(running), 32'd1);
    #2 nCR = 1'b0;
    #1 checkOut("asyncRst", 0, 0, 0, 8'h00, 8'h00, 8'h00);
    @(negedge CP);
    nCR = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
